mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arb_starve_cnt.sv | 36 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types for the instruction/data memory arbiter   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int STARVE_W = 4;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_DM = 2'b10
  } arb_state_t;

  typedef logic [STARVE_W-1:0] starve_cnt_t;
  typedef logic [DATA_W-1:0]   word_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_if : fetch, data and shared-memory ports of mem_arbiter  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic  if_req;
  word_t if_addr;
  word_t if_rdata;
  logic  if_ack;

  logic  dm_req;
  logic  dm_we;
  word_t dm_addr;
  word_t dm_wdata;
  word_t dm_rdata;
  logic  dm_ack;

  logic  mem_req;
  logic  mem_we;
  word_t mem_addr;
  word_t mem_wdata;
  word_t mem_rdata;
  logic  mem_ready;

  logic  stall_if;

  // Arbiter side: serves the two requesters and masters the memory.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, stall_if
  );

  // Environment side: the requesters plus the memory device.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall_if
  );

endinterface
`default_nettype wire

// File: rtl/mem_arb_starve_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_starve_cnt : saturating count of data grants made while a    |
// |                      fetch waits; Revision 1.0                       |
// +----------------------------------------------------------------------+
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  wire  clock,
  input  wire  resetn,
  input  wire  inc,
  input  wire  clr,
  output logic at_limit
);

  localparam starve_cnt_t C_LIMIT = starve_cnt_t'(STARVE_LIMIT);
  localparam starve_cnt_t C_ONE   = starve_cnt_t'(1);

  starve_cnt_t r_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != C_LIMIT)) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  assign at_limit = (r_cnt == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : shares one single-port memory between instruction      |
// |               fetch and data access, data-first with anti-starvation |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  wire           clock,
  input  wire           resetn,
  mem_arbiter_if.slave  bus
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic  w_if_elig;
  logic  w_dm_elig;
  logic  w_grant_if;
  logic  w_grant_dm;
  logic  w_done_if;
  logic  w_done_dm;
  logic  w_at_limit;

  logic  r_mem_req;
  logic  r_mem_we;
  word_t r_mem_addr;
  word_t r_mem_wdata;
  logic  r_if_ack;
  logic  r_dm_ack;
  word_t r_if_rdata;
  word_t r_dm_rdata;

  // A requester in its ack cycle still holds req high; it must not re-win.
  assign w_if_elig = bus.if_req && !r_if_ack;
  assign w_dm_elig = bus.dm_req && !r_dm_ack;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_dm  = 1'b0;
    w_done_if   = 1'b0;
    w_done_dm   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_if_elig && (!w_dm_elig || w_at_limit)) begin
          w_grant_if  = 1'b1;
          w_state_nxt = BUSY_IF;
        end else if (w_dm_elig) begin
          w_grant_dm  = 1'b1;
          w_state_nxt = BUSY_DM;
        end
      end
      BUSY_IF: begin
        if (bus.mem_ready) begin
          w_done_if   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      BUSY_DM: begin
        if (bus.mem_ready) begin
          w_done_dm   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Memory request register: loaded at grant, held through wait states.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_if) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= bus.if_addr;
      r_mem_wdata <= '0;
    end else if (w_grant_dm) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= bus.dm_we;
      r_mem_addr  <= bus.dm_addr;
      r_mem_wdata <= bus.dm_wdata;
    end else if (w_done_if || w_done_dm) begin
      r_mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_if_ack   <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_if_ack <= w_done_if;
      r_dm_ack <= w_done_dm;
      if (w_done_if) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (w_done_dm) begin
        r_dm_rdata <= bus.mem_rdata;
      end
    end
  end

  mem_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clock    (clock),
    .resetn   (resetn),
    .inc      (w_grant_dm && bus.if_req),
    .clr      (w_grant_if),
    .at_limit (w_at_limit)
  );

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.stall_if  = bus.if_req && !r_if_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : directed bench with a transaction-level model       |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic clock;
  logic resetn;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: who owns the memory, what was presented, and pending acks.
  int          owner = 0;        // 0 none, 1 fetch, 2 data
  int          starve = 0;
  logic        e_mem_req = 0, e_mem_we = 0, e_if_ack = 0, e_dm_ack = 0;
  logic [31:0] e_mem_addr = 0, e_mem_wdata = 0, e_if_rdata = 0, e_dm_rdata = 0;
  logic        dm_known = 1;
  logic        fin_if, fin_dm, want_if, want_dm;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      owner = 0; starve = 0;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
      e_if_ack = 0; e_dm_ack = 0; e_if_rdata = 0; e_dm_rdata = 0; dm_known = 1;
    end else begin
      fin_if  = (owner == 1) && bus.mem_ready;
      fin_dm  = (owner == 2) && bus.mem_ready;
      want_if = (owner == 0) && bus.if_req && !e_if_ack;
      want_dm = (owner == 0) && bus.dm_req && !e_dm_ack;
      if (fin_if) e_if_rdata = bus.mem_rdata;
      if (fin_dm) begin
        e_dm_rdata = bus.mem_rdata;
        dm_known   = !e_mem_we;
      end
      if (fin_if || fin_dm) begin
        owner = 0;
        e_mem_req = 0;
      end
      if (want_if && (!want_dm || starve == STARVE_LIMIT)) begin
        owner = 1; e_mem_req = 1; e_mem_we = 0; e_mem_addr = bus.if_addr;
        starve = 0;
      end else if (want_dm) begin
        owner = 2; e_mem_req = 1; e_mem_we = bus.dm_we;
        e_mem_addr = bus.dm_addr; e_mem_wdata = bus.dm_wdata;
        if (bus.if_req && starve < STARVE_LIMIT) starve = starve + 1;
      end
      e_if_ack = fin_if;
      e_dm_ack = fin_dm;
    end
  end

  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      chk("cyc mem_req", {31'd0, bus.mem_req}, {31'd0, e_mem_req});
      chk("cyc if_ack", {31'd0, bus.if_ack}, {31'd0, e_if_ack});
      chk("cyc dm_ack", {31'd0, bus.dm_ack}, {31'd0, e_dm_ack});
      chk("cyc stall_if", {31'd0, bus.stall_if}, {31'd0, bus.if_req && !e_if_ack});
      chk("cyc if_rdata", bus.if_rdata, e_if_rdata);
      if (dm_known) chk("cyc dm_rdata", bus.dm_rdata, e_dm_rdata);
      if (e_mem_req) begin
        chk("cyc mem_addr", bus.mem_addr, e_mem_addr);
        chk("cyc mem_we", {31'd0, bus.mem_we}, {31'd0, e_mem_we});
        if (e_mem_we) chk("cyc mem_wdata", bus.mem_wdata, e_mem_wdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    bus.mem_rdata = 0; bus.mem_ready = 0;
    #3;
    chk("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst if_ack", {31'd0, bus.if_ack}, 32'd0);
    chk("rst dm_ack", {31'd0, bus.dm_ack}, 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst if_rdata", bus.if_rdata, 32'd0);
    chk("rst dm_rdata", bus.dm_rdata, 32'd0);
    tick(); tick();
    resetn = 1'b1;

    // Lone fetch, zero-wait memory.
    bus.mem_ready = 1; bus.mem_rdata = 32'h2002_0005;
    bus.if_req = 1; bus.if_addr = 32'h0000_0040;
    #1 chk("t1 stall c0", {31'd0, bus.stall_if}, 32'd1);
    tick();
    chk("t1 mem_req c1", {31'd0, bus.mem_req}, 32'd1);
    chk("t1 mem_addr c1", bus.mem_addr, 32'h0000_0040);
    chk("t1 mem_we c1", {31'd0, bus.mem_we}, 32'd0);
    chk("t1 stall c1", {31'd0, bus.stall_if}, 32'd1);
    tick();
    chk("t1 if_ack c2", {31'd0, bus.if_ack}, 32'd1);
    chk("t1 if_rdata c2", bus.if_rdata, 32'h2002_0005);
    chk("t1 stall c2", {31'd0, bus.stall_if}, 32'd0);
    bus.if_req = 0;
    tick();
    chk("t1 if_ack c3", {31'd0, bus.if_ack}, 32'd0);

    // Simultaneous requests: data write first, fetch granted in the dm_ack cycle.
    bus.mem_rdata = 32'h1111_2222;
    bus.if_req = 1; bus.if_addr = 32'h0000_0080;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h10; bus.dm_wdata = 32'hDEAD_BEEF;
    tick();
    chk("t2 mem_we", {31'd0, bus.mem_we}, 32'd1);
    chk("t2 mem_addr", bus.mem_addr, 32'h10);
    chk("t2 mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("t2 dm_ack", {31'd0, bus.dm_ack}, 32'd1);
    chk("t2 mem_req drop", {31'd0, bus.mem_req}, 32'd0);
    bus.dm_req = 0; bus.dm_we = 0;
    tick();
    chk("t2 if grant", {31'd0, bus.mem_req}, 32'd1);
    chk("t2 if addr", bus.mem_addr, 32'h0000_0080);
    tick();
    chk("t2 if_ack", {31'd0, bus.if_ack}, 32'd1);
    chk("t2 if_rdata", bus.if_rdata, 32'h1111_2222);
    bus.if_req = 0;
    tick();

    // Data read with three memory wait cycles.
    bus.mem_ready = 0;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3 mem_req held", {31'd0, bus.mem_req}, 32'd1);
      chk("t3 mem_addr held", bus.mem_addr, 32'h200);
      chk("t3 no early ack", {31'd0, bus.dm_ack}, 32'd0);
    end
    bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE_0001;
    tick();
    chk("t3 dm_ack", {31'd0, bus.dm_ack}, 32'd1);
    chk("t3 dm_rdata", bus.dm_rdata, 32'hCAFE_0001);
    bus.dm_req = 0;
    tick();
    chk("t3 dm_ack width", {31'd0, bus.dm_ack}, 32'd0);

    // Reset in the middle of a fetch.
    bus.mem_ready = 0;
    bus.if_req = 1; bus.if_addr = 32'h300;
    tick();
    chk("t4 mem_req busy", {31'd0, bus.mem_req}, 32'd1);
    tick();
    #3 resetn = 1'b0; bus.mem_ready = 1; bus.mem_rdata = 32'h0BAD_0BAD;
    #1 chk("t4 async mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("t4 async mem_addr", bus.mem_addr, 32'd0);
    tick();
    resetn = 1'b1;
    chk("t4 no ack", {31'd0, bus.if_ack}, 32'd0);
    chk("t4 idle after rel", {31'd0, bus.mem_req}, 32'd0);
    bus.mem_rdata = 32'h0000_3300;
    tick();
    chk("t4 regrant", {31'd0, bus.mem_req}, 32'd1);
    chk("t4 regrant addr", bus.mem_addr, 32'h300);
    tick();
    chk("t4 if_ack", {31'd0, bus.if_ack}, 32'd1);
    chk("t4 if_rdata", bus.if_rdata, 32'h0000_3300);
    bus.if_req = 0;
    tick();

    // mem_ready in IDLE with nothing requested is ignored.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5 idle mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("t5 idle acks", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
    end
    bus.dm_req = 1; bus.dm_addr = 32'h240;
    tick();
    chk("t5 grant after idle", bus.mem_addr, 32'h240);
    tick();
    chk("t5 dm_ack", {31'd0, bus.dm_ack}, 32'd1);
    bus.dm_req = 0;
    tick();

    // Starvation: the fetch withdraws in each data ack cycle so only the
    // counter, not the ack-cycle rule, can let it win.
    bus.if_addr = 32'h500;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      bus.if_req = 1; bus.dm_req = 1; bus.dm_we = 0;
      bus.dm_addr = 32'h400 + 32'(i * 4); bus.mem_rdata = 32'h7000_0000 + 32'(i);
      tick();
      chk("t6 data wins", bus.mem_addr, 32'h400 + 32'(i * 4));
      bus.if_req = 0;
      tick();
      chk("t6 dm_ack", {31'd0, bus.dm_ack}, 32'd1);
      bus.dm_req = 0;
      tick();
    end
    bus.if_req = 1; bus.dm_req = 1; bus.dm_addr = 32'h600;
    tick();
    chk("t6 fetch wins", bus.mem_addr, 32'h500);
    chk("t6 fetch we", {31'd0, bus.mem_we}, 32'd0);
    bus.dm_req = 0;
    tick();
    chk("t6 if_ack", {31'd0, bus.if_ack}, 32'd1);
    bus.if_req = 0;
    tick();
    bus.if_req = 1; bus.dm_req = 1;
    tick();
    chk("t6 count cleared", bus.mem_addr, 32'h600);
    bus.if_req = 0;
    tick();
    bus.dm_req = 0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
